counter_seq_ctrl: RTL



---
 rtl/counter_seq_ctrl_pkg.sv | 14 +
 rtl/counter_seq_ctrl_prescaler_tick.sv | 34 +++
 rtl/counter_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// rtl/counter_seq_ctrl_pkg.sv - shared state encoding and default widths for the counter sequencer
package counter_seq_ctrl_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/counter_seq_ctrl_prescaler_tick.sv
// rtl/counter_seq_ctrl_prescaler_tick.sv - step-rate divider, tick every div_i+1 cycles
module prescaler_tick
    import counter_seq_ctrl_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] div_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - load/run/done sequencer driving an external loadable up-counter
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   start_val,
    input  logic [WIDTH-1:0]   end_val,
    input  logic [PRESC_W-1:0] presc,
    input  logic               auto_reload,
    input  logic [WIDTH-1:0]   cnt_q,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_data,
    output logic               cnt_en,
    output logic               cnt_oe,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [WIDTH-1:0]   end_q, end_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               auto_q, auto_d;
    logic               oe_q, oe_d;
    logic               aborted_q, aborted_d;
    logic               accept;
    logic               tick;
    logic               at_end;

    // Prescaler only free-runs in RUN so the first step lands presc+1 cycles after LOAD.
    prescaler_tick #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_RUN),
        .div_i  (presc_q),
        .tick_o (tick)
    );

    assign at_end = (cnt_q == end_q);

    always_comb begin
        state_d   = state_q;
        oe_d      = oe_q;
        aborted_d = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (at_end) begin
                    state_d = ST_DONE;
                    oe_d    = 1'b1;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end else if (auto_q) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            aborted_d = 1'b1;
            oe_d      = 1'b0;
        end
        // Result stays visible in IDLE; any fresh LOAD hides it again.
        if (state_d == ST_LOAD) begin
            oe_d = 1'b0;
        end
    end

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        presc_d = presc_q;
        auto_d  = auto_q;
        if (accept) begin
            start_d = start_val;
            end_d   = end_val;
            presc_d = presc;
            auto_d  = auto_reload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            presc_q   <= '0;
            auto_q    <= 1'b0;
            oe_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            presc_q   <= presc_d;
            auto_q    <= auto_d;
            oe_q      <= oe_d;
            aborted_q <= aborted_d;
        end
    end

    // cnt_en is combinational on cnt_q so the step that reaches end_val is the last one.
    assign cnt_load      = (state_q == ST_LOAD);
    assign cnt_load_data = cnt_load ? start_q : '0;
    assign cnt_en        = (state_q == ST_RUN) && tick && !at_end;
    assign cnt_oe        = oe_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign aborted       = aborted_q;

endmodule
